// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory copy engine: default geometry and
// the FSM state encoding.
package dmem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: copies len words from src_addr.. to dst_addr.. in a
// single-port data memory, one read cycle then one write cycle per word.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           copy request, honoured only when idle
//   src_addr        first source word address (captured on accepted start)
//   dst_addr        first destination word address (captured on accepted start)
//   len             word count 0..2^ADDR_W (captured on accepted start)
//   busy            high while a copy is in RD/WR/DONE
//   done            one-cycle completion pulse
//   mem_address     memory word address
//   mem_wdata       memory write data
//   write_en        memory write strobe
//   read_en         memory read strobe
//   mem_rdata       memory read data, valid the cycle after read_en
//   checksum        XOR of all copied words (only with DMEM_COPY_CHECKSUM_EN)
//
// Build option: define DMEM_COPY_CHECKSUM_EN to add the checksum port.
module dmem_copy_engine
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = dmem_pkg::ADDR_W,
  parameter int unsigned DATA_W = dmem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              write_en,
  output logic              read_en,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              start_acc;

  assign start_acc = (state_q == ST_IDLE) && start;

  // Next state, plus the registered outputs for the state being entered so
  // that strobes and address line up with the state itself.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          idx_d   = '0;
          state_d = (len != '0) ? ST_RD : ST_DONE;
        end
      end
      ST_RD: begin
        state_d = ST_WR;
      end
      ST_WR: begin
        idx_d   = idx_q + (ADDR_W + 1)'(1);
        state_d = (idx_d < len_q) ? ST_RD : ST_DONE;
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Address sums are ADDR_W wide, so they wrap modulo 2^ADDR_W.
    unique case (state_d)
      ST_RD: begin
        busy_d = 1'b1;
        rd_d   = 1'b1;
        addr_d = src_d + idx_d[ADDR_W-1:0];
      end
      ST_WR: begin
        busy_d = 1'b1;
        wr_d   = 1'b1;
        addr_d = dst_d + idx_d[ADDR_W-1:0];
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, counters, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign read_en     = rd_q;
  assign write_en    = wr_q;
  assign mem_address = addr_q;

  // Read data only arrives during the WR cycle, so it is forwarded directly.
  assign mem_wdata = (state_q == ST_WR) ? mem_rdata : '0;

`ifdef DMEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running XOR of every word passing through a WR cycle.
  always_comb begin
    checksum_d = checksum_q;
    if (start_acc) begin
      checksum_d = '0;
    end else if (state_q == ST_WR) begin
      checksum_d = checksum_q ^ mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule : dmem_copy_engine

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine with a behavioural memory and a
// word-level reference copy model.
module tb_dmem_copy_engine;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 64;
  localparam int unsigned NW = 256;
  localparam int unsigned VW = 4 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic          write_en;
  logic          read_en;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] mem     [NW];
  logic [DW-1:0] ref_mem [NW];
  logic          preload;
  logic [DW-1:0] exp_cs;
  int            checks = 0;
  int            errors = 0;

  dmem_copy_engine #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .write_en   (write_en),
    .read_en    (read_en),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data valid the cycle after read_en.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < NW; k++) mem[k] <= ref_mem[k];
    end else begin
      if (write_en) mem[mem_address] <= mem_wdata;
      if (read_en) mem_rdata <= mem[mem_address];
    end
  end

  function automatic logic [VW-1:0] cur_obs();
    return {busy, done, read_en, write_en, mem_address, mem_wdata};
  endfunction

  task automatic check(input string tag, input int k, input logic [VW-1:0] obs,
                       input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Issue one copy and check every cycle against the latency rule: word i is
  // read in cycle 2i+1, written in cycle 2i+2, done in cycle 2n+1.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW:0] n, input int pulse_k, input int rst_k,
                          input string tag);
    int            nn;
    int            last;
    int            i;
    int            bad;
    logic [VW-1:0] exp;
    logic [AW-1:0] a;
    logic [AW-1:0] sa;
    logic [DW-1:0] v;
    nn = int'(n);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    len      = (AW + 1)'($urandom_range(1, 24));
    exp_cs   = '0;
    last     = (rst_k > 0) ? rst_k : 2 * nn + 3;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == rst_k) begin
        rst = 1'b0;
        #1;
        check({tag, "_in_reset"}, k, cur_obs(), '0);
`ifdef DMEM_COPY_CHECKSUM_EN
        check({tag, "_cs_reset"}, k, VW'(checksum), '0);
`endif
      end else begin
        exp = '0;
        if (nn > 0 && k <= 2 * nn) begin
          i  = (k - 1) / 2;
          sa = AW'((int'(s) + i) % NW);
          if (k % 2 == 1) begin
            exp = {1'b1, 1'b0, 1'b1, 1'b0, sa, DW'(0)};
          end else begin
            a          = AW'((int'(d) + i) % NW);
            v          = ref_mem[sa];
            exp        = {1'b1, 1'b0, 1'b0, 1'b1, a, v};
            ref_mem[a] = v;
            exp_cs     = exp_cs ^ v;
          end
        end else if (k == 2 * nn + 1) begin
          exp = {1'b1, 1'b1, 1'b0, 1'b0, AW'(0), DW'(0)};
        end
        check({tag, "_cycle"}, k, cur_obs(), exp);
      end
      if (k == pulse_k) begin
        start    = 1'b1;
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        len      = (AW + 1)'($urandom_range(1, 24));
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    if (rst_k > 0) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_held_reset"}, rst_k + 1, cur_obs(), '0);
      rst = 1'b1;
      exp_cs = '0;
    end
    bad = 0;
    for (int k = 0; k < NW; k++) if (mem[k] !== ref_mem[k]) bad++;
    check({tag, "_mem_words_differing"}, 0, VW'(bad), '0);
`ifdef DMEM_COPY_CHECKSUM_EN
    check({tag, "_checksum"}, 0, VW'(checksum), VW'(exp_cs));
`endif
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    preload  = 1'b0;
    exp_cs   = '0;
    for (int k = 0; k < NW; k++) begin
      ref_mem[k] = (k <= 16) ? DW'(k + 1) : {$urandom, $urandom};
    end
    #1;
    check("reset_outputs", 0, cur_obs(), '0);
    preload = 1'b1;
    @(posedge clk);
    #1;
    preload = 1'b0;
    @(negedge clk);
    check("reset_held", 0, cur_obs(), '0);
    rst = 1'b1;

    run_copy(8'd0, 8'd32, 9'd4, 0, 0, "basic");
    check("basic_word35", 0, VW'(mem[35]), VW'(4));
`ifdef DMEM_COPY_CHECKSUM_EN
    check("basic_cs_is_4", 0, VW'(checksum), VW'(4));
`endif
    run_copy(8'd5, 8'd60, 9'd0, 0, 0, "len0");
    run_copy(8'd254, 8'd40, 9'd4, 0, 0, "wrap");
    check("wrap_word42", 0, VW'(mem[42]), VW'(1));
    run_copy(8'd100, 8'd120, 9'd4, 3, 0, "restart_ignored");
    run_copy(8'd8, 8'd70, 9'd4, 0, 4, "mid_reset");
    run_copy(8'd10, 8'd80, 9'd1, 0, 0, "post_reset");
    for (int r = 0; r < 6; r++) begin
      run_copy(AW'($urandom), AW'($urandom), (AW + 1)'($urandom_range(1, 24)),
               (r % 2 == 1) ? 2 : 0, 0, "random");
    end
    run_copy(8'd20, 8'd23, 9'd6, 0, 0, "overlap");
    run_copy(8'd7, 8'd130, 9'd256, 0, 0, "full_len");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dmem_copy_engine
